// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: captures a request word on START and reports
// the index of every set bit, one per cycle, in priority order.
module prio_enc_seq #(
    parameter int unsigned N          = 8,
    parameter int unsigned W          = $clog2(N),
    parameter bit          HIGH_FIRST = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         START,
    input  logic [N-1:0] IN,
    output logic [W-1:0] Y,
    output logic         VALID,
    output logic         Done,
    output logic         BUSY
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]   r_state, w_state_d;
    logic [N-1:0] r_pend, w_pend_d;
    logic [W-1:0] r_y, w_y_d;
    logic         r_valid, w_valid_d;
    logic         r_done, w_done_d;

    logic [N-1:0] w_src;
    logic [N-1:0] w_rest;
    logic [W-1:0] w_idx;

    function automatic logic [W-1:0] pick(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        // Scan away from the winning end so the last hit is the winner.
        for (int i = 0; i < int'(N); i++) begin
            if (HIGH_FIRST) begin
                if (v[i]) idx = W'(i);
            end else begin
                if (v[int'(N) - 1 - i]) idx = W'(int'(N) - 1 - i);
            end
        end
        return idx;
    endfunction

    // In IDLE the winner comes straight from IN so the first index is ready
    // the cycle after START is sampled.
    assign w_src  = (r_state == S_SCAN) ? r_pend : IN;
    assign w_idx  = pick(w_src);
    assign w_rest = w_src & ~(N'(1) << w_idx);

    always_comb begin
        w_state_d = r_state;
        w_pend_d  = r_pend;
        w_y_d     = r_y;
        w_valid_d = 1'b0;
        w_done_d  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START && !EN) begin
                    if (IN == '0) begin
                        w_y_d    = '0;
                        w_done_d = 1'b1;
                    end else begin
                        w_y_d     = w_idx;
                        w_valid_d = 1'b1;
                        w_pend_d  = w_rest;
                        if (w_rest == '0) begin
                            w_done_d = 1'b1;
                        end else begin
                            w_state_d = S_SCAN;
                        end
                    end
                end
            end
            S_SCAN: begin
                if (!EN) begin
                    w_y_d     = w_idx;
                    w_valid_d = 1'b1;
                    w_pend_d  = w_rest;
                    if (w_rest == '0) begin
                        w_done_d  = 1'b1;
                        w_state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_pend_d;
            r_y     <= w_y_d;
            r_valid <= w_valid_d;
            r_done  <= w_done_d;
        end
    end

    assign Y     = r_y;
    assign VALID = r_valid;
    assign Done  = r_done;
    assign BUSY  = (r_state == S_SCAN);

endmodule

// File: tb/tb_prio_enc_seq.sv
// Bench for prio_enc_seq: an 8-bit high-first and a 16-bit low-first instance
// share control inputs and are checked every cycle against an index-list model.
module tb_prio_enc_seq;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        START;
    logic [7:0]  in_a;
    logic [15:0] in_b;
    logic [2:0]  y_a;
    logic [3:0]  y_b;
    logic        valid_a, done_a, busy_a;
    logic        valid_b, done_b, busy_b;

    prio_enc_seq #(.N(8), .HIGH_FIRST(1'b1)) u_dut_a (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .START (START),
        .IN    (in_a),
        .Y     (y_a),
        .VALID (valid_a),
        .Done  (done_a),
        .BUSY  (busy_a)
    );

    prio_enc_seq #(.N(16), .HIGH_FIRST(1'b0)) u_dut_b (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .START (START),
        .IN    (in_b),
        .Y     (y_b),
        .VALID (valid_b),
        .Done  (done_b),
        .BUSY  (busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass;
    int n_total;

    // Model: on an accepted start the set-bit indices are listed in service
    // order; each enabled cycle emits the next list entry.
    int   lst [2][16];
    int   hd [2];
    int   ln [2];
    logic m_busy [2];
    logic m_valid [2];
    logic m_done [2];
    int   m_y [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 1'b0;
            m_valid[d] = 1'b0;
            m_done[d]  = 1'b0;
            m_y[d]     = 0;
            hd[d]      = 0;
            ln[d]      = 0;
        end
    endtask

    task automatic emit(input int d);
        m_y[d]     = lst[d][hd[d]];
        hd[d]      = hd[d] + 1;
        m_valid[d] = 1'b1;
        if (hd[d] == ln[d]) begin
            m_done[d] = 1'b1;
            m_busy[d] = 1'b0;
        end else begin
            m_busy[d] = 1'b1;
        end
    endtask

    task automatic model_step(input int d, input int n, input bit hf, input logic [15:0] v);
        m_valid[d] = 1'b0;
        m_done[d]  = 1'b0;
        if (!m_busy[d]) begin
            if (START && !EN) begin
                ln[d] = 0;
                hd[d] = 0;
                for (int k = 0; k < n; k++) begin
                    int i;
                    i = hf ? (n - 1 - k) : k;
                    if (v[i]) begin
                        lst[d][ln[d]] = i;
                        ln[d] = ln[d] + 1;
                    end
                end
                if (ln[d] == 0) begin
                    m_y[d]    = 0;
                    m_done[d] = 1'b1;
                end else begin
                    emit(d);
                end
            end
        end else if (!EN) begin
            emit(d);
        end
    endtask

    task automatic compare_all();
        chk("a_y",     int'(y_a),     m_y[0]);
        chk("a_valid", int'(valid_a), int'(m_valid[0]));
        chk("a_done",  int'(done_a),  int'(m_done[0]));
        chk("a_busy",  int'(busy_a),  int'(m_busy[0]));
        chk("b_y",     int'(y_b),     m_y[1]);
        chk("b_valid", int'(valid_b), int'(m_valid[1]));
        chk("b_done",  int'(done_b),  int'(m_done[1]));
        chk("b_busy",  int'(busy_b),  int'(m_busy[1]));
    endtask

    // One clock: model advances on the same edge the DUTs sample, then compare.
    task automatic cyc();
        @(posedge CLK);
        model_step(0, 8, 1'b1, {8'h00, in_a});
        model_step(1, 16, 1'b0, in_b);
        #1;
        compare_all();
    endtask

    task automatic lit_a(input string nm, input int y, input int v, input int dn, input int b);
        chk({nm, "_y"}, int'(y_a), y);
        chk({nm, "_valid"}, int'(valid_a), v);
        chk({nm, "_done"}, int'(done_a), dn);
        chk({nm, "_busy"}, int'(busy_a), b);
    endtask

    task automatic lit_b(input string nm, input int y, input int v, input int dn, input int b);
        chk({nm, "_y"}, int'(y_b), y);
        chk({nm, "_valid"}, int'(valid_b), v);
        chk({nm, "_done"}, int'(done_b), dn);
        chk({nm, "_busy"}, int'(busy_b), b);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        compare_all();
        #2;
        RST = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        RST   = 1'b1;
        EN    = 1'b1;
        START = 1'b0;
        in_a  = '0;
        in_b  = '0;
        model_reset();
        #12;
        lit_a("rst_a", 0, 0, 0, 0);
        lit_b("rst_b", 0, 0, 0, 0);
        RST = 1'b0;

        // No-request start.
        EN = 1'b0; START = 1'b1;
        cyc();
        lit_a("zero_in", 0, 0, 1, 0);
        START = 1'b0;
        cyc();

        // One-hot inputs, each a single-cycle sweep.
        START = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_a = 8'(1 << k);
            cyc();
            lit_a($sformatf("onehot%0d", k), k, 1, 1, 0);
        end
        START = 1'b0;
        for (int k = 0; k < 20; k++) cyc();

        // Multi-bit sweep 5,4,0.
        in_a = 8'b0011_0001; START = 1'b1;
        cyc(); lit_a("multi0", 5, 1, 0, 1);
        START = 1'b0;
        cyc(); lit_a("multi1", 4, 1, 0, 1);
        cyc(); lit_a("multi2", 0, 1, 1, 0);
        for (int k = 0; k < 20; k++) cyc();

        // Pause with a START pulse that must be ignored.
        in_a = 8'hF0; START = 1'b1;
        cyc(); lit_a("pause0", 7, 1, 0, 1);
        START = 1'b0;
        cyc(); lit_a("pause1", 6, 1, 0, 1);
        EN = 1'b1; START = 1'b1; in_a = 8'h0F;
        cyc(); lit_a("pause2", 6, 0, 0, 1);
        cyc(); lit_a("pause3", 6, 0, 0, 1);
        EN = 1'b0; START = 1'b0;
        cyc(); lit_a("pause4", 5, 1, 0, 1);
        cyc(); lit_a("pause5", 4, 1, 1, 0);
        for (int k = 0; k < 20; k++) cyc();

        // Low-first 16-bit instance.
        in_b = 16'h8006; START = 1'b1;
        cyc(); lit_b("lowfirst0", 1, 1, 0, 1);
        START = 1'b0;
        cyc(); lit_b("lowfirst1", 2, 1, 0, 1);
        cyc(); lit_b("lowfirst2", 15, 1, 1, 0);
        EN = 1'b1; START = 1'b1;
        cyc(); lit_b("en_idle0", 15, 0, 0, 0);
        cyc(); lit_b("en_idle1", 15, 0, 0, 0);
        EN = 1'b0; START = 1'b0;
        for (int k = 0; k < 20; k++) cyc();

        // Reset mid-sweep, then a fresh single-bit sweep.
        in_a = 8'b0010_0110; START = 1'b1;
        cyc(); lit_a("midrst0", 5, 1, 0, 1);
        START = 1'b0;
        rst_pulse();
        lit_a("midrst1", 0, 0, 0, 0);
        in_a = 8'b0000_0010; START = 1'b1;
        cyc(); lit_a("midrst2", 1, 1, 1, 0);
        START = 1'b0;

        // Randomized traffic, including back-to-back starts and pauses.
        for (int c = 0; c < 4000; c++) begin
            EN    = ($urandom_range(0, 4) == 0);
            START = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       in_a = 8'h00;
                1:       in_a = 8'(1 << $urandom_range(0, 7));
                default: in_a = 8'($urandom);
            endcase
            in_b = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 499) == 0) rst_pulse();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prio_enc_seq.md
Name: prio_enc_seq

Overview:
- Parametrised, registered successor to the team's 8-to-3 binary priority encoder, which uses active-low EN, IN, Y and Done.
- Instead of reporting only the winning request, it captures an N-bit request word on START and reports the index of every set bit, one per cycle, in priority order.
- Done marks the end of each sweep.
- Used wherever a request vector must be serviced bit by bit, e.g. interrupt or channel dispatch.

Parameters:
N, 8, request vector width (N >= 2).
W, $clog2(N), index width of Y (derived; do not override).
HIGH_FIRST, 1, 1 = highest set index served first (legacy ordering); 0 = lowest set index first.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  active-low enable, as in the legacy encoder: 0 = operate, 1 = hold/pause.
START  input  1  load IN and begin a sweep; sampled only when idle and EN=0.
IN  input  N  request vector.
Y  output  W  index of the currently reported request bit.
VALID  output  1  Y holds a new index this cycle.
Done  output  1  one-cycle pulse: sweep finished.
BUSY  output  1  sweep in progress (SCAN state).

Behaviour:
- All outputs are registered.
- Reset (async, RST=1):
  - Y=0, VALID=0, Done=0, BUSY=0.
  - Internal pending mask = 0; state = IDLE.
  - Reset asserted mid-sweep aborts the sweep immediately, with no Done pulse.
- Priority function pick(v):
  - HIGH_FIRST=1: index of the most significant set bit of v.
  - HIGH_FIRST=0: index of the least significant set bit of v.
- State machine: IDLE, SCAN.
- IDLE, with BUSY=0:
  - Condition for starting: START=1 and EN=0 at a rising edge. Otherwise nothing changes; VALID=0, Done=0.
  - If IN=0 when starting: Y<=0, VALID<=0, Done<=1; stay IDLE. This is the "no request" indication.
  - If IN!=0 when starting:
    - Y<=pick(IN), VALID<=1.
    - pending <= IN with that bit cleared.
    - If pending becomes 0 (single bit set): Done<=1, stay IDLE.
    - Otherwise Done<=0, BUSY<=1, go to SCAN.
  - Latency: the first index appears on the cycle after START is sampled.
- SCAN, with BUSY=1:
  - EN=0: each cycle Y<=pick(pending), VALID<=1, and that bit is cleared from pending.
    - If the cleared bit was the last one: Done<=1 on the same cycle as the final VALID, BUSY<=0, go to IDLE.
  - EN=1: pause. VALID<=0, Done<=0; pending, Y and BUSY hold. The sweep resumes when EN returns to 0.
  - START is ignored in SCAN. Changes on IN are ignored after capture.
- Sweep length = popcount(IN) VALID cycles, excluding pause cycles.
  - Done is asserted exactly once per accepted START.
- Y holds its last value whenever VALID=0, except on the IN=0 case, where it is forced to 0.
- Back-to-back sweeps: START may be sampled on the cycle BUSY falls (state is IDLE). The next sweep's first VALID follows immediately, with no gap cycle.

Test Plan:
1. Reset, then EN=0, START with IN=8'b00000000 -> next cycle Done=1, VALID=0, Y=0, BUSY=0.
2. HIGH_FIRST=1, IN=8'b10000000 -> one cycle with Y=7, VALID=1, Done=1; BUSY stays 0. Repeat for each one-hot input 0..7 -> Y equals the bit index.
3. HIGH_FIRST=1, IN=8'b00110001 -> Y=5, 4, 0 on three consecutive VALID cycles; Done=1 only with Y=0; BUSY=1 during the first two.
4. IN=8'b11110000, with EN=1 for 2 cycles after the second output -> outputs 7, 6, then 2 cycles of VALID=0 with Y=6 held, then 5, 4 with Done on 4. A START pulse during the pause is ignored.
5. HIGH_FIRST=0, N=16, IN=16'h8006 -> Y=1, 2, 15; Done with 15. EN=1 while idle with START=1 -> no response.
6. Assert RST mid-sweep of IN=8'b00100110 after the first output -> all outputs 0 immediately. After release, a new START with IN=8'b00000010 gives Y=1 with Done=1.
